fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
- Multi-cycle fetch/execute sequencer for the 16-bit core.
- Owns the program counter and drives the instruction-memory request handshake.
- Pulses the instruction-register load enable so the IR captures memory read data.
- Hands each instruction to the execute unit with a start/done handshake, then updates the PC sequentially or by branch target.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- MEM_TIMEOUT, 255, max cycles FETCH waits for mem_ack before faulting (1..65535).

Ports:
- clk, in, 1, clock, rising edge.
- rst_n, in, 1, reset, asynchronous, active-low.
- run_en, in, 1, level; core may fetch while high.
- mem_req, out, 1, instruction read request.
- mem_addr, out, 16, word address of the fetch; equals pc_out.
- mem_ack, in, 1, read data valid on mem_rdata this cycle (external to block; routed to IR ins_in).
- il_out, out, 1, IR load enable; to IR il_in.
- halt_in, in, 1, decoded HALT from IR opcode; sampled in DECODE.
- exe_start, out, 1, one-cycle pulse starting execute.
- exe_done, in, 1, execute complete.
- br_take, in, 1, branch taken; qualified by exe_done.
- br_target, in, 16, branch target; qualified by exe_done and br_take.
- pc_out, out, 16, current PC.
- state_out, out, 3, encoded FSM state for debug.
- instr_cnt, out, 16, retired-instruction counter, wraps.
- fault_out, out, 1, sticky memory-timeout fault.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc_out=RESET_PC, instr_cnt=0, fault_out=0, timeout counter=0.
  - mem_req, il_out and exe_start are all 0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4, FAULT=5.
- IDLE:
  - Outputs quiet.
  - run_en=1 -> FETCH next cycle.
- FETCH:
  - mem_req=1 (Moore), mem_addr=pc_out held stable.
  - Timeout counter increments each cycle without mem_ack.
  - mem_ack=1 -> il_out=1 combinationally that same cycle, so the IR captures data on that edge; counter clears; go to DECODE.
  - Counter reaching MEM_TIMEOUT without ack -> FAULT.
  - Ack on the same cycle the counter reaches MEM_TIMEOUT: ack wins.
- DECODE:
  - One cycle; IR is valid.
  - halt_in=1 -> HALT; PC not advanced; instr_cnt not incremented.
  - Otherwise -> EXEC, with exe_start=1 during the DECODE->EXEC transition cycle. exe_start is registered, so it is high for exactly the first cycle of EXEC.
- EXEC:
  - Waits for exe_done.
  - On exe_done: pc <= br_take ? br_target : pc+1 (mod 2^16, so 16'hFFFF -> 16'h0000); instr_cnt+1 (wraps 16'hFFFF -> 0).
  - Next state: run_en ? FETCH : IDLE.
  - Minimum fetch-to-fetch latency: FETCH(ack) 1 + DECODE 1 + EXEC 1 = 3 cycles.
- HALT:
  - Outputs quiet.
  - Exits to IDLE only when run_en=0; a later run_en=1 refetches at the same PC.
  - Software re-arms by toggling run_en.
- FAULT:
  - fault_out=1; all handshake outputs 0.
  - Leaves only on reset.
- Ignored inputs:
  - mem_ack outside FETCH.
  - exe_done outside EXEC.
  - br_take/br_target without exe_done.
- run_en deassert mid-operation:
  - FETCH holds mem_req until ack or timeout; no request is abandoned.
  - The instruction completes; the FSM returns to IDLE after EXEC.
- Async reset mid-FETCH or mid-EXEC:
  - mem_req and exe_start drop immediately.
  - PC returns to RESET_PC.
- il_out is never high outside FETCH. exe_start is never high for two consecutive cycles.

Test Plan:
- Reset, run_en=1, memory acks 1 cycle after each req, exe_done 1 cycle after exe_start, br_take=0 -> mem_addr sequence 0x0000, 0x0001, 0x0002; il_out exactly one pulse per fetch; instr_cnt=3 after three exe_done.
- Branch: at PC=0x0005, exe_done with br_take=1, br_target=0x0100 -> next mem_addr=0x0100; instr_cnt increments by 1.
- Wrap: RESET_PC=16'hFFFF, one non-branch instruction -> next fetch at 0x0000.
- HALT: halt_in=1 in DECODE at PC=0x0010 -> state HALT, no exe_start, pc stays 0x0010. Then run_en 0 then 1 -> FETCH at 0x0010.
- Timeout: MEM_TIMEOUT=4, never ack -> fault_out=1 after 4 FETCH cycles; mem_req=0; run_en toggles ignored until rst_n pulse clears to IDLE with pc=RESET_PC.
- Corner cases:
  - run_en=0 asserted mid-FETCH with ack delayed 3 cycles -> mem_req held until ack, instruction executes, then IDLE.
  - Spurious exe_done in FETCH -> no PC change.

Source files
------------

// File: rtl/fetch_seq_if.sv
// Instruction-memory request and execute-unit handshake bundle
// shared between fetch_seq (master) and its memory/execute peers.
interface fetch_seq_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic        il_out;
  logic        halt_in;
  logic        exe_start;
  logic        exe_done;
  logic        br_take;
  logic [15:0] br_target;

  modport master (
    output mem_req,
    output mem_addr,
    output il_out,
    output exe_start,
    input  mem_ack,
    input  halt_in,
    input  exe_done,
    input  br_take,
    input  br_target
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  il_out,
    input  exe_start,
    output mem_ack,
    output halt_in,
    output exe_done,
    output br_take,
    output br_target
  );
endinterface

// File: rtl/fetch_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit core:
// owns the PC, drives the I-mem request and the execute handshake.
module fetch_seq #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  fetch_seq_if.master bus,
  output logic [15:0] pc_out,
  output logic [2:0]  state_out,
  output logic [15:0] instr_cnt,
  output logic        fault_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] tmo_inc;
  logic        start_q, start_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    start_d = 1'b0;
    tmo_inc = tmo_q + 16'd1;
    unique case (state_q)
      S_IDLE: begin
        if (run_en) state_d = S_FETCH;
      end
      S_FETCH: begin
        // a late ack still beats the timeout
        if (bus.mem_ack) begin
          tmo_d   = '0;
          state_d = S_DECODE;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO) state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        if (bus.halt_in) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
          start_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (bus.exe_done) begin
          pc_d    = bus.br_take ? bus.br_target
                                : pc_q + 16'd1;
          cnt_d   = cnt_q + 16'd1;
          state_d = run_en ? S_FETCH : S_IDLE;
        end
      end
      S_HALT: begin
        if (!run_en) state_d = S_IDLE;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      tmo_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
    end
  end

  assign bus.mem_req   = (state_q == S_FETCH);
  assign bus.mem_addr  = pc_q;
  assign bus.il_out    = bus.mem_req & bus.mem_ack;
  assign bus.exe_start = start_q;

  assign pc_out    = pc_q;
  assign state_out = state_q;
  assign instr_cnt = cnt_q;
  assign fault_out = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_seq.sv
// Randomized scoreboard bench for fetch_seq: a driver acts as memory
// and execute unit, a monitor checks fetch addresses and retire counts.
module tb_fetch_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_en = 1'b0;
  logic [15:0] pc_out;
  logic [2:0]  state_out;
  logic [15:0] instr_cnt;
  logic        fault_out;

  fetch_seq_if bus();

  fetch_seq #(
    .RESET_PC   (16'h0000),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_en   (run_en),
    .bus      (bus),
    .pc_out   (pc_out),
    .state_out(state_out),
    .instr_cnt(instr_cnt),
    .fault_out(fault_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_cnt_q[$];
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_cnt = 16'h0000;
  logic        prev_start = 1'b0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // drive just after the rising edge, monitor on the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.il_out) begin
        chk("il_only_in_fetch", 32'(state_out), 32'd1);
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fetch_unexpected actual=%h required=none",
                   bus.mem_addr);
        end else begin
          chk("fetch_addr", 32'(bus.mem_addr),
              32'(exp_addr_q.pop_front()));
        end
      end
      if (bus.exe_start) begin
        chk("start_not_twice", 32'(prev_start), 32'd0);
        chk("start_in_exec", 32'(state_out), 32'd3);
        if (exp_cnt_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL start_unexpected actual=1 required=0");
        end else begin
          chk("cnt_at_start", 32'(instr_cnt),
              32'(exp_cnt_q.pop_front()));
        end
      end
      if (bus.mem_req)
        chk("addr_eq_pc", 32'(bus.mem_addr), 32'(pc_out));
      prev_start = bus.exe_start;
    end
  end

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    while (!bus.mem_req) begin
      tick();
      n++;
      if (n > 50) begin
        fail_now("wait_mem_req");
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic run_instr(int ack_dly, bit halt, bit br,
                           logic [15:0] tgt, int done_dly,
                           bit drop_run);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    exp_addr_q.push_back(m_pc);
    for (int i = 0; i < ack_dly; i++) begin
      bus.exe_done  = 1'($urandom_range(0, 1));
      bus.br_take   = 1'b1;
      bus.br_target = 16'($urandom);
      if (drop_run && i == 0) run_en = 1'b0;
      tick();
    end
    bus.exe_done = 1'b0;
    bus.br_take  = 1'b0;
    bus.mem_ack  = 1'b1;
    tick();
    chk("decode_state", 32'(state_out), 32'd2);
    chk("pc_hold_fetch", 32'(pc_out), 32'(m_pc));
    bus.mem_ack = 1'b0;
    bus.halt_in = halt;
    if (!halt) exp_cnt_q.push_back(m_cnt);
    tick();
    bus.halt_in = 1'b0;
    if (halt) begin
      chk("halt_state", 32'(state_out), 32'd4);
      chk("halt_no_start", 32'(bus.exe_start), 32'd0);
      chk("halt_pc", 32'(pc_out), 32'(m_pc));
      chk("halt_cnt", 32'(instr_cnt), 32'(m_cnt));
      return;
    end
    for (int i = 0; i < done_dly; i++) begin
      bus.mem_ack = 1'($urandom_range(0, 1));
      tick();
    end
    bus.mem_ack   = 1'b0;
    bus.exe_done  = 1'b1;
    bus.br_take   = br;
    bus.br_target = tgt;
    tick();
    bus.exe_done  = 1'b0;
    bus.br_take   = 1'b0;
    bus.br_target = 16'($urandom);
    m_pc  = br ? tgt : m_pc + 16'd1;
    m_cnt = m_cnt + 16'd1;
    chk("pc_after_exec", 32'(pc_out), 32'(m_pc));
    chk("cnt_after_exec", 32'(instr_cnt), 32'(m_cnt));
    chk("state_after_exec", 32'(state_out),
        run_en ? 32'd1 : 32'd0);
    run_en = 1'b1;
  endtask

  task automatic halt_rearm();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_stays", 32'(state_out), 32'd4);
    end
    chk("halt_pc_kept", 32'(pc_out), 32'(m_pc));
    run_en = 1'b0;
    tick();
    chk("halt_to_idle", 32'(state_out), 32'd0);
    tick();
    chk("idle_no_req", 32'(bus.mem_req), 32'd0);
    run_en = 1'b1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_start", 32'(bus.exe_start), 32'd0);
    chk("rst_il", 32'(bus.il_out), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'h0000);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    chk("rst_fault", 32'(fault_out), 32'd0);
    exp_addr_q.delete();
    exp_cnt_q.delete();
    m_pc  = 16'h0000;
    m_cnt = 16'h0000;
    bus.mem_ack  = 1'b0;
    bus.exe_done = 1'b0;
    bus.halt_in  = 1'b0;
    bus.br_take  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bit ok;
    int n;
    bus.mem_ack   = 1'b0;
    bus.halt_in   = 1'b0;
    bus.exe_done  = 1'b0;
    bus.br_take   = 1'b0;
    bus.br_target = 16'h0000;
    tick();
    chk("por_state", 32'(state_out), 32'd0);
    chk("por_pc", 32'(pc_out), 32'h0000);
    chk("por_cnt", 32'(instr_cnt), 32'd0);
    chk("por_fault", 32'(fault_out), 32'd0);
    chk("por_req", 32'(bus.mem_req), 32'd0);
    chk("por_start", 32'(bus.exe_start), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_wait_run", 32'(state_out), 32'd0);
    run_en = 1'b1;

    for (int i = 0; i < 5; i++)
      run_instr(1, 1'b0, 1'b0, 16'h0000, 1, 1'b0);
    run_instr(0, 1'b0, 1'b1, 16'h0100, 0, 1'b0);
    run_instr(2, 1'b0, 1'b1, 16'hFFFF, 1, 1'b0);
    run_instr(3, 1'b0, 1'b0, 16'h1234, 2, 1'b0);
    run_instr(1, 1'b0, 1'b1, 16'h0010, 0, 1'b0);
    run_instr(0, 1'b1, 1'b0, 16'h0000, 0, 1'b0);
    halt_rearm();
    run_instr(3, 1'b0, 1'b0, 16'h0000, 1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int  a;
      int  d;
      bit  h;
      bit  b;
      bit  dr;
      a  = int'($urandom_range(0, 3));
      d  = int'($urandom_range(0, 3));
      h  = ($urandom_range(0, 7) == 0);
      b  = ($urandom_range(0, 3) == 0);
      dr = (a > 0) && ($urandom_range(0, 5) == 0);
      run_instr(a, h, b, 16'($urandom), d, dr);
      if (h) halt_rearm();
    end

    wait_req(ok);
    n = 0;
    while (bus.mem_req && n < 20) begin
      n++;
      tick();
    end
    chk("timeout_cycles", 32'(n), 32'd4);
    chk("fault_state", 32'(state_out), 32'd5);
    chk("fault_flag", 32'(fault_out), 32'd1);
    run_en = 1'b0;
    tick();
    run_en = 1'b1;
    bus.mem_ack = 1'b1;
    tick();
    tick();
    bus.mem_ack = 1'b0;
    chk("fault_sticky", 32'(state_out), 32'd5);
    chk("fault_no_req", 32'(bus.mem_req), 32'd0);
    chk("fault_no_il", 32'(bus.il_out), 32'd0);
    do_reset();

    wait_req(ok);
    tick();
    do_reset();

    wait_req(ok);
    exp_addr_q.push_back(m_pc);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    chk("exec_started", 32'(bus.exe_start), 32'd1);
    do_reset();
    run_en = 1'b0;
    tick();

    chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("cnt_q_drained", 32'(exp_cnt_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=done");
    $fatal(1);
  end
endmodule
